if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage of the 5-stage pipeline; branches/jumps resolve in MEM.
//  Holds the PC and drives the instruction-memory address.
//  Selects next PC = PC+PC_STEP or the MEM-stage redirect target, and owns the IF/ID pipeline register.
//  Consumes the next-PC select (PCSrc) and target from MEM; its IF/ID outputs feed decode.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  PC_STEP   4              sequential PC increment, bytes
//  NOP_INSTR 32'h0000_0000  instruction word injected as a bubble
// PORTS
//  Clk           in   1   pipeline clock, rising edge
//  Rst           in   1   asynchronous, active-low reset
//  Stall         in   1   hazard unit: hold PC and IF/ID (load-use)
//  PCSrc         in   1   MEM stage: taken branch/jump, redirect
//  BranchTarget  in   32  MEM stage redirect address
//  ImemInstr     in   32  instruction memory read data (combinational read of ImemAddr)
//  ImemAddr      out  32  current PC to instruction memory
//  IFID_Instr    out  32  registered instruction to decode
//  IFID_PCPlus4  out  32  registered PC+PC_STEP of IFID_Instr
//  IFID_Valid    out  1   1 = IF/ID holds a real instruction, 0 = bubble
// BEHAVIOUR
//  Reset (async, Rst=0): PC=RESET_PC, IFID_Instr=NOP_INSTR, IFID_PCPlus4=0, IFID_Valid=0, state=RUN.
//  Effective next-PC select is a 32-bit 2:1 choice: PCSrc=0 -> PC+PC_STEP, 1 -> BranchTarget.
//  PC+PC_STEP is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//  FSM states: RUN, HOLD, REDIRECT (2-bit encoding). Per rising edge, priority order:
//   1 PCSrc=1 (any state, overrides Stall): PC<=BranchTarget; IF/ID<=bubble
//     (Instr=NOP_INSTR, Valid=0, PCPlus4 unchanged); state<=REDIRECT.
//   2 Stall=1: PC and all IF/ID regs hold; state<=HOLD.
//   3 else: PC<=PC+PC_STEP; IF/ID<={ImemInstr, PC+PC_STEP, 1}; state<=RUN.
//  REDIRECT: exactly one cycle; next edge follows rules 1-3 (target instruction enters IF/ID).
//  HOLD exits on the first edge with Stall=0 and no PCSrc; the held instruction is not duplicated or lost.
//  ImemAddr = PC, combinational from the PC register; fetch-to-IF/ID latency 1 cycle.
//  BranchTarget is used unaligned as given; alignment is the producer's responsibility.
//  Rst asserted mid-stall or mid-redirect: immediate return to the reset values above.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: adds outputs StallCnt[31:0] and RedirectCnt[31:0].
//   - Both counters reset to 0.
//   - StallCnt increments on each edge taking rule 2.
//   - RedirectCnt increments on each edge taking rule 1.
//   - Both wrap modulo 2^32.
//  Undefined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package: FSM state typedef/localparams (ST_RUN, ST_HOLD, ST_REDIRECT) and the NOP encoding.
//  One sub-module: if_id_reg, holding the IF/ID register with hold (stall) and clear (bubble) controls.
//  PC register, incrementer, next-PC select and FSM stay in if_fetch_stage.
// TESTING
//  1 Reset with Rst=0 then release; ImemInstr=32'h2001_0005
//    -> ImemAddr=0, Valid=0; after 1st edge IFID_Instr=32'h2001_0005, PCPlus4=4, Valid=1, ImemAddr=4.
//  2 Stall=1 for 3 cycles at PC=8
//    -> ImemAddr stays 8 and IF/ID unchanged for 3 edges; next edge resumes at PC=12.
//  3 PCSrc=1, BranchTarget=32'h40 at PC=16
//    -> next edge: ImemAddr=32'h40, Valid=0, Instr=NOP; following edge: PCPlus4=32'h44, Valid=1.
//  4 PCSrc=1 and Stall=1 on the same edge
//    -> redirect wins: PC=BranchTarget, bubble in IF/ID, state REDIRECT.
//  5 PC=32'hFFFF_FFFC, no stall -> next ImemAddr=0, IFID_PCPlus4=0.
//  6 Assert Rst during a Stall, and separately on a PCSrc edge
//    -> outputs take reset values immediately; with IF_PERF_CNT_EN, both counters read 0.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared fetch-stage FSM states and bubble encoding
package if_fetch_stage_pkg;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_HOLD     = 2'd1,
      ST_REDIRECT = 2'd2
   } fetch_state_t;

   localparam logic [31:0] NOP_ENC = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// rtl/if_fetch_stage_if_id_reg.sv - IF/ID pipeline register with hold and bubble-clear
module if_id_reg
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        i_clear,
   input  logic        i_hold,
   input  logic [31:0] i_instr,
   input  logic [31:0] i_pc_plus,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc_plus,
   output logic        o_valid
);

   logic [31:0] r_instr;
   logic [31:0] r_pc_plus;
   logic        r_valid;

   // A bubble keeps the old PC+step; only the instruction and valid bit are cleared.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_instr   <= NOP_INSTR;
         r_pc_plus <= 32'h0000_0000;
         r_valid   <= 1'b0;
      end else if (i_clear) begin
         r_instr <= NOP_INSTR;
         r_valid <= 1'b0;
      end else if (!i_hold) begin
         r_instr   <= i_instr;
         r_pc_plus <= i_pc_plus;
         r_valid   <= 1'b1;
      end
   end

   assign o_instr   = r_instr;
   assign o_pc_plus = r_pc_plus;
   assign o_valid   = r_valid;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - PC, next-PC select, fetch FSM and IF/ID; IF_PERF_CNT_EN adds stall/redirect counters
module if_fetch_stage
   import if_fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] PC_STEP   = 32'd4,
   parameter logic [31:0] NOP_INSTR = NOP_ENC
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        Stall,
   input  logic        PCSrc,
   input  logic [31:0] BranchTarget,
   input  logic [31:0] ImemInstr,
   output logic [31:0] ImemAddr,
   output logic [31:0] IFID_Instr,
   output logic [31:0] IFID_PCPlus4,
   output logic        IFID_Valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] StallCnt,
   output logic [31:0] RedirectCnt
`endif
);

   fetch_state_t r_state;
   logic [31:0]  r_pc;
   logic [31:0]  w_pc_plus;
   logic [31:0]  w_pc_next;
   logic         w_hold;

   assign w_pc_plus = r_pc + PC_STEP;
   assign w_pc_next = PCSrc ? BranchTarget : w_pc_plus;
   assign w_hold    = Stall && !PCSrc;

   // Redirect outranks stall in every state, so all legal states share one rule set.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_state <= ST_RUN;
         r_pc    <= RESET_PC;
      end else begin
         case (r_state)
            ST_RUN, ST_HOLD, ST_REDIRECT: begin
               if (PCSrc) begin
                  r_state <= ST_REDIRECT;
                  r_pc    <= w_pc_next;
               end else if (Stall) begin
                  r_state <= ST_HOLD;
               end else begin
                  r_state <= ST_RUN;
                  r_pc    <= w_pc_next;
               end
            end
            default: r_state <= ST_RUN;
         endcase
      end
   end

   assign ImemAddr = r_pc;

   if_id_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_if_id_reg (
      .Clk       (Clk),
      .Rst       (Rst),
      .i_clear   (PCSrc),
      .i_hold    (w_hold),
      .i_instr   (ImemInstr),
      .i_pc_plus (w_pc_plus),
      .o_instr   (IFID_Instr),
      .o_pc_plus (IFID_PCPlus4),
      .o_valid   (IFID_Valid)
   );

`ifdef IF_PERF_CNT_EN
   logic [31:0] r_stall_cnt;
   logic [31:0] r_redirect_cnt;

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         r_stall_cnt    <= 32'h0000_0000;
         r_redirect_cnt <= 32'h0000_0000;
      end else begin
         if (PCSrc)
            r_redirect_cnt <= r_redirect_cnt + 32'd1;
         if (w_hold)
            r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign StallCnt    = r_stall_cnt;
   assign RedirectCnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage against a behavioural model
module tb_if_fetch_stage;

   logic        Clk;
   logic        Rst;
   logic        Stall;
   logic        PCSrc;
   logic [31:0] BranchTarget;
   logic [31:0] ImemInstr;
   logic [31:0] ImemAddr;
   logic [31:0] IFID_Instr;
   logic [31:0] IFID_PCPlus4;
   logic        IFID_Valid;
`ifdef IF_PERF_CNT_EN
   logic [31:0] StallCnt;
   logic [31:0] RedirectCnt;
`endif

   int checks = 0;
   int errors = 0;

   logic        use_fixed;
   logic [31:0] fixed_word;

   // behavioural model state
   logic [31:0] m_pc, m_instr, m_pcp4;
   logic        m_valid;
   logic [31:0] m_stall_cnt, m_redir_cnt;

   if_fetch_stage dut (
      .Clk          (Clk),
      .Rst          (Rst),
      .Stall        (Stall),
      .PCSrc        (PCSrc),
      .BranchTarget (BranchTarget),
      .ImemInstr    (ImemInstr),
      .ImemAddr     (ImemAddr),
      .IFID_Instr   (IFID_Instr),
      .IFID_PCPlus4 (IFID_PCPlus4),
      .IFID_Valid   (IFID_Valid)
`ifdef IF_PERF_CNT_EN
      ,
      .StallCnt     (StallCnt),
      .RedirectCnt  (RedirectCnt)
`endif
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   function automatic logic [31:0] imem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   always_comb ImemInstr = use_fixed ? fixed_word : imem(ImemAddr);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 32'h0; m_instr = 32'h0; m_pcp4 = 32'h0; m_valid = 1'b0;
      m_stall_cnt = 32'h0; m_redir_cnt = 32'h0;
   endtask

   task automatic compare_all();
      check("ImemAddr", ImemAddr, m_pc);
      check("IFID_Instr", IFID_Instr, m_instr);
      check("IFID_PCPlus4", IFID_PCPlus4, m_pcp4);
      check("IFID_Valid", {31'b0, IFID_Valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
      check("StallCnt", StallCnt, m_stall_cnt);
      check("RedirectCnt", RedirectCnt, m_redir_cnt);
`endif
   endtask

   // One clock: model advances from the inputs held across the edge, then outputs are compared.
   task automatic step();
      @(posedge Clk);
      if (!Rst) begin
         model_reset();
      end else if (PCSrc) begin
         m_pc = BranchTarget; m_instr = 32'h0; m_valid = 1'b0;
         m_redir_cnt = m_redir_cnt + 1;
      end else if (Stall) begin
         m_stall_cnt = m_stall_cnt + 1;
      end else begin
         m_instr = use_fixed ? fixed_word : imem(m_pc);
         m_pcp4  = m_pc + 32'd4;
         m_valid = 1'b1;
         m_pc    = m_pc + 32'd4;
      end
      #1;
      compare_all();
   endtask

   task automatic async_reset_check();
      #2;
      Rst = 1'b0;
      #1;
      model_reset();
      compare_all();
      check("rst_addr_lit", ImemAddr, 32'h0);
      check("rst_valid_lit", {31'b0, IFID_Valid}, 32'h0);
      #2;
      Rst = 1'b1;
      Stall = 1'b0; PCSrc = 1'b0;
   endtask

   initial begin
      Rst = 1'b0; Stall = 1'b0; PCSrc = 1'b0; BranchTarget = 32'h0;
      use_fixed = 1'b1; fixed_word = 32'h2001_0005;
      model_reset();
      #2;
      compare_all();
      check("t1_reset_addr", ImemAddr, 32'h0);
      check("t1_reset_valid", {31'b0, IFID_Valid}, 32'h0);
      #4 Rst = 1'b1;

      // 1: first fetch lands in IF/ID one edge later
      step();
      check("t1_instr", IFID_Instr, 32'h2001_0005);
      check("t1_pcp4", IFID_PCPlus4, 32'h4);
      check("t1_valid", {31'b0, IFID_Valid}, 32'h1);
      check("t1_addr", ImemAddr, 32'h4);
      use_fixed = 1'b0;

      // 2: stall three edges at PC=8
      step();
      check("t2_pc8", ImemAddr, 32'h8);
      Stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         check("t2_hold_addr", ImemAddr, 32'h8);
         check("t2_hold_pcp4", IFID_PCPlus4, 32'h8);
      end
      Stall = 1'b0;
      step();
      check("t2_resume", ImemAddr, 32'hC);
      check("t2_instr", IFID_Instr, imem(32'h8));

      // 3: redirect at PC=16
      step();
      check("t3_pc16", ImemAddr, 32'h10);
      PCSrc = 1'b1; BranchTarget = 32'h40;
      step();
      check("t3_addr", ImemAddr, 32'h40);
      check("t3_bubble_valid", {31'b0, IFID_Valid}, 32'h0);
      check("t3_bubble_instr", IFID_Instr, 32'h0);
      PCSrc = 1'b0;
      step();
      check("t3_pcp4", IFID_PCPlus4, 32'h44);
      check("t3_valid", {31'b0, IFID_Valid}, 32'h1);

      // 4: redirect wins over stall
      PCSrc = 1'b1; Stall = 1'b1; BranchTarget = 32'h0000_0123;
      step();
      check("t4_addr", ImemAddr, 32'h0000_0123);
      check("t4_valid", {31'b0, IFID_Valid}, 32'h0);
      Stall = 1'b0;

      // 5: PC wrap
      BranchTarget = 32'hFFFF_FFFC;
      step();
      PCSrc = 1'b0;
      step();
      check("t5_addr", ImemAddr, 32'h0);
      check("t5_pcp4", IFID_PCPlus4, 32'h0);

      // 6: reset mid-stall, then reset on a redirect edge
      Stall = 1'b1;
      step();
      step();
      async_reset_check();
      step();
      step();
      PCSrc = 1'b1; BranchTarget = 32'h80;
      async_reset_check();

      // randomized phase
      for (int n = 0; n < 600; n++) begin
         Stall = ($urandom_range(0, 99) < 30);
         PCSrc = ($urandom_range(0, 99) < 12);
         BranchTarget = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         if ($urandom_range(0, 99) == 0)
            async_reset_check();
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
